ram64_arbiter: RTL

//  Two-requester round-robin arbiter and sequencer for one RAM64 (64 x 16-bit) array.

---
 rtl/ram64_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ram64_arbiter.sv
// ram64_arbiter: two-port round-robin front end for a single RAM64 (64 x 16).
// Requests from P0/P1 are granted one per cycle into a registered command stage
// that drives the RAM pins. Responses return two cycles after acceptance.
// A clear engine sweeps CLEAR_VALUE into all 64 words after reset or on demand.
//
// Handshake: a request transfers on a rising edge where pN_valid && pN_ready.
// pN_ready is combinational on pN_valid. A requester holds valid and its payload
// stable until it sees ready. pN_rvalid is a one-cycle strobe with no back-pressure.
module ram64_arbiter #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [15:0] CLEAR_VALUE    = 16'h0000,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clear_start,
    output logic        busy,
    input  logic        p0_valid,
    input  logic        p0_we,
    input  logic [5:0]  p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ready,
    output logic        p0_rvalid,
    output logic [15:0] p0_rdata,
    input  logic        p1_valid,
    input  logic        p1_we,
    input  logic [5:0]  p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ready,
    output logic        p1_rvalid,
    output logic [15:0] p1_rdata,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [5:0]  ram_address,
    input  logic [15:0] ram_out
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state_q;
    logic [5:0]  clr_cnt_q;
    logic        cmd_valid_q;
    logic        cmd_we_q;
    logic        cmd_port_q;
    logic [5:0]  cmd_addr_q;
    logic [15:0] cmd_wdata_q;
    logic        rr_q;
    logic        p0_rvalid_q;
    logic        p1_rvalid_q;
    logic [15:0] p0_rdata_q;
    logic [15:0] p1_rdata_q;

    logic        accept_en;
    logic        grant0;
    logic        grant1;

    // Grant selection: one winner per cycle, only in RUN with no clear requested.
    always_comb begin
        accept_en = RST_N && (state_q == ST_RUN) && !clear_start;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (accept_en) begin
            if (p0_valid && (!p1_valid || FIXED_PRIORITY || !rr_q)) begin
                grant0 = 1'b1;
            end else if (p1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // FSM, clear counter, command stage, rr pointer and response registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= 6'd0;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_port_q  <= 1'b0;
            cmd_addr_q  <= 6'd0;
            cmd_wdata_q <= 16'd0;
            rr_q        <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= 16'd0;
            p1_rdata_q  <= 16'd0;
        end else begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            cmd_valid_q <= grant0 || grant1;
            case (state_q)
                ST_CLEAR: begin
                    // Mirror the sweep into the command fields so idle pins hold the last value.
                    cmd_addr_q  <= clr_cnt_q;
                    cmd_wdata_q <= CLEAR_VALUE;
                    clr_cnt_q   <= clr_cnt_q + 6'd1;
                    if (clr_cnt_q == 6'd63) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    // The command accepted last cycle executes now, even under clear_start.
                    if (cmd_valid_q) begin
                        if (cmd_port_q) begin
                            p1_rvalid_q <= 1'b1;
                            p1_rdata_q  <= cmd_we_q ? 16'd0 : ram_out;
                        end else begin
                            p0_rvalid_q <= 1'b1;
                            p0_rdata_q  <= cmd_we_q ? 16'd0 : ram_out;
                        end
                    end
                    if (grant0) begin
                        cmd_we_q    <= p0_we;
                        cmd_port_q  <= 1'b0;
                        cmd_addr_q  <= p0_addr;
                        cmd_wdata_q <= p0_wdata;
                        rr_q        <= 1'b1;
                    end else if (grant1) begin
                        cmd_we_q    <= p1_we;
                        cmd_port_q  <= 1'b1;
                        cmd_addr_q  <= p1_addr;
                        cmd_wdata_q <= p1_wdata;
                        rr_q        <= 1'b0;
                    end
                    if (clear_start) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= 6'd0;
                    end
                end
            endcase
        end
    end

    // RAM pins and status; load and busy are suppressed while reset is held.
    always_comb begin
        busy        = RST_N && (state_q == ST_CLEAR);
        ram_address = (state_q == ST_CLEAR) ? clr_cnt_q : cmd_addr_q;
        ram_in      = (state_q == ST_CLEAR) ? CLEAR_VALUE : cmd_wdata_q;
        ram_load    = RST_N && ((state_q == ST_CLEAR) || (cmd_valid_q && cmd_we_q));
        p0_ready    = grant0;
        p1_ready    = grant1;
        p0_rvalid   = p0_rvalid_q;
        p1_rvalid   = p1_rvalid_q;
        p0_rdata    = p0_rdata_q;
        p1_rdata    = p1_rdata_q;
    end

endmodule
